up_axi_lite_bridge: RTL and testbench

- AXI4-Lite slave that converts bus transactions into the single-cycle up_* request/acknowledge microprocessor interface used by the system ID register block and its peers.
- Sits directly upstream of the register block: it drives up_wreq/up_waddr/up_wdata and up_rreq/up_raddr, and consumes up_wack, up_rack and up_rdata.
- Read and write channels are independent and may be in flight at the same time.
- Each channel has a bounded acknowledge timeout.

---
 rtl/up_axi_lite_bridge_if.sv | 42 ++++
 rtl/up_axi_lite_bridge.sv | 219 +++++++++++++++++++++
 tb/tb_up_axi_lite_bridge.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/up_axi_lite_bridge_if.sv
// ---------------------------------------------------------------------------
// up_axi_lite_bridge_if
// AXI4-Lite bus bundle between a bus master and the up_axi_lite_bridge.
//   slave  modport : bridge side (valids/addresses/data in, readies/responses out)
//   master modport : bus master side (the mirror image)
// Parameter AXI_ADDRESS_WIDTH sets the byte address width of AW and AR.
// ---------------------------------------------------------------------------
interface up_axi_lite_bridge_if #(
   parameter int AXI_ADDRESS_WIDTH = 16
);
   logic                         up_axi_awvalid;
   logic [AXI_ADDRESS_WIDTH-1:0] up_axi_awaddr;
   logic                         up_axi_awready;
   logic                         up_axi_wvalid;
   logic [31:0]                  up_axi_wdata;
   logic [3:0]                   up_axi_wstrb;
   logic                         up_axi_wready;
   logic                         up_axi_bvalid;
   logic [1:0]                   up_axi_bresp;
   logic                         up_axi_bready;
   logic                         up_axi_arvalid;
   logic [AXI_ADDRESS_WIDTH-1:0] up_axi_araddr;
   logic                         up_axi_arready;
   logic                         up_axi_rvalid;
   logic [1:0]                   up_axi_rresp;
   logic [31:0]                  up_axi_rdata;
   logic                         up_axi_rready;

   modport slave (
      input  up_axi_awvalid, up_axi_awaddr, up_axi_wvalid, up_axi_wdata, up_axi_wstrb,
      input  up_axi_bready, up_axi_arvalid, up_axi_araddr, up_axi_rready,
      output up_axi_awready, up_axi_wready, up_axi_bvalid, up_axi_bresp,
      output up_axi_arready, up_axi_rvalid, up_axi_rresp, up_axi_rdata
   );

   modport master (
      output up_axi_awvalid, up_axi_awaddr, up_axi_wvalid, up_axi_wdata, up_axi_wstrb,
      output up_axi_bready, up_axi_arvalid, up_axi_araddr, up_axi_rready,
      input  up_axi_awready, up_axi_wready, up_axi_bvalid, up_axi_bresp,
      input  up_axi_arready, up_axi_rvalid, up_axi_rresp, up_axi_rdata
   );
endinterface

// File: rtl/up_axi_lite_bridge.sv
// ---------------------------------------------------------------------------
// up_axi_lite_bridge
// AXI4-Lite slave that turns bus reads/writes into single-cycle up_* requests
// and waits (with a bounded timeout) for the matching acknowledge.
// Ports:
//   up_clk, up_rstn         : clock, asynchronous active-low reset
//   s_axi (slave modport)   : AXI4-Lite AW/W/B and AR/R channels
//   up_wreq/up_waddr/up_wdata, up_wack          : write request side
//   up_rreq/up_raddr, up_rdata/up_rack          : read request side
// Read and write channels are fully independent FSMs; each allows a single
// outstanding transaction. All outputs come straight from flops.
// ---------------------------------------------------------------------------
module up_axi_lite_bridge #(
   parameter int ADDRESS_WIDTH     = 12,
   parameter int AXI_ADDRESS_WIDTH = 16,
   parameter int TIMEOUT_BITS      = 5
) (
   input  logic                     up_clk,
   input  logic                     up_rstn,
   up_axi_lite_bridge_if.slave      s_axi,
   output logic                     up_wreq,
   output logic [ADDRESS_WIDTH-1:0] up_waddr,
   output logic [31:0]              up_wdata,
   input  logic                     up_wack,
   output logic                     up_rreq,
   output logic [ADDRESS_WIDTH-1:0] up_raddr,
   input  logic [31:0]              up_rdata,
   input  logic                     up_rack
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ACCEPT = 3'd1,
      ST_REQ    = 3'd2,
      ST_WAIT   = 3'd3,
      ST_RESP   = 3'd4
   } state_t;

   localparam logic [1:0]              RESP_OKAY   = 2'b00;
   localparam logic [1:0]              RESP_SLVERR = 2'b10;
   localparam logic [TIMEOUT_BITS-1:0] CNT_ZERO    = {TIMEOUT_BITS{1'b0}};
   localparam logic [TIMEOUT_BITS-1:0] CNT_ONE     = {{(TIMEOUT_BITS-1){1'b0}}, 1'b1};
   localparam logic [TIMEOUT_BITS-1:0] CNT_MAX     = {TIMEOUT_BITS{1'b1}};

   state_t                   w_state_q, w_state_d, r_state_q, r_state_d;
   logic [TIMEOUT_BITS-1:0]  w_cnt_q, w_cnt_d, r_cnt_q, r_cnt_d;
   logic [ADDRESS_WIDTH-1:0] waddr_q, waddr_d, raddr_q, raddr_d;
   logic [31:0]              wdata_q, wdata_d, rdata_q, rdata_d;
   logic [1:0]               bresp_q, bresp_d, rresp_q, rresp_d;
   logic                     awready_q, awready_d, bvalid_q, bvalid_d, wreq_q, wreq_d;
   logic                     arready_q, arready_d, rvalid_q, rvalid_d, rreq_q, rreq_d;

   // Byte strobes and the discarded address bits are intentionally not used.
   logic unused_s;
   assign unused_s = ^{s_axi.up_axi_wstrb, s_axi.up_axi_awaddr, s_axi.up_axi_araddr};

   // Write channel next-state logic; outputs are decoded from the next state
   // so that they can be registered without a cycle of lag.
   always_comb begin
      w_state_d = w_state_q;
      w_cnt_d   = w_cnt_q;
      waddr_d   = waddr_q;
      wdata_d   = wdata_q;
      bresp_d   = bresp_q;
      case (w_state_q)
         ST_IDLE: begin
            // Address and data must both be present; never handshake one alone.
            if (s_axi.up_axi_awvalid && s_axi.up_axi_wvalid) begin
               w_state_d = ST_ACCEPT;
            end else begin
               w_state_d = ST_IDLE;
            end
         end
         ST_ACCEPT: begin
            waddr_d   = s_axi.up_axi_awaddr[ADDRESS_WIDTH+1:2];
            wdata_d   = s_axi.up_axi_wdata;
            w_state_d = ST_REQ;
         end
         ST_REQ: begin
            w_cnt_d   = CNT_ZERO;
            w_state_d = ST_WAIT;
         end
         ST_WAIT: begin
            // Ack is checked first so it wins over a simultaneous timeout.
            if (up_wack) begin
               bresp_d   = RESP_OKAY;
               w_state_d = ST_RESP;
            end else if (w_cnt_q == CNT_MAX) begin
               bresp_d   = RESP_SLVERR;
               w_state_d = ST_RESP;
            end else begin
               w_cnt_d   = w_cnt_q + CNT_ONE;
            end
         end
         ST_RESP: begin
            if (s_axi.up_axi_bready) begin
               bresp_d   = RESP_OKAY;
               w_state_d = ST_IDLE;
            end else begin
               w_state_d = ST_RESP;
            end
         end
         default: begin
            w_state_d = ST_IDLE;
         end
      endcase
      awready_d = (w_state_d == ST_ACCEPT);
      wreq_d    = (w_state_d == ST_REQ);
      bvalid_d  = (w_state_d == ST_RESP);
   end

   // Read channel next-state logic; mirrors the write channel.
   always_comb begin
      r_state_d = r_state_q;
      r_cnt_d   = r_cnt_q;
      raddr_d   = raddr_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      case (r_state_q)
         ST_IDLE: begin
            if (s_axi.up_axi_arvalid) begin
               r_state_d = ST_ACCEPT;
            end else begin
               r_state_d = ST_IDLE;
            end
         end
         ST_ACCEPT: begin
            raddr_d   = s_axi.up_axi_araddr[ADDRESS_WIDTH+1:2];
            r_state_d = ST_REQ;
         end
         ST_REQ: begin
            r_cnt_d   = CNT_ZERO;
            r_state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (up_rack) begin
               rdata_d   = up_rdata;
               rresp_d   = RESP_OKAY;
               r_state_d = ST_RESP;
            end else if (r_cnt_q == CNT_MAX) begin
               rdata_d   = 32'h0000_0000;
               rresp_d   = RESP_SLVERR;
               r_state_d = ST_RESP;
            end else begin
               r_cnt_d   = r_cnt_q + CNT_ONE;
            end
         end
         ST_RESP: begin
            if (s_axi.up_axi_rready) begin
               rdata_d   = 32'h0000_0000;
               rresp_d   = RESP_OKAY;
               r_state_d = ST_IDLE;
            end else begin
               r_state_d = ST_RESP;
            end
         end
         default: begin
            r_state_d = ST_IDLE;
         end
      endcase
      arready_d = (r_state_d == ST_ACCEPT);
      rreq_d    = (r_state_d == ST_REQ);
      rvalid_d  = (r_state_d == ST_RESP);
   end

   // State, counter and output registers for both channels.
   always_ff @(posedge up_clk or negedge up_rstn) begin
      if (!up_rstn) begin
         w_state_q <= ST_IDLE;
         r_state_q <= ST_IDLE;
         w_cnt_q   <= CNT_ZERO;
         r_cnt_q   <= CNT_ZERO;
         waddr_q   <= {ADDRESS_WIDTH{1'b0}};
         raddr_q   <= {ADDRESS_WIDTH{1'b0}};
         wdata_q   <= 32'h0000_0000;
         rdata_q   <= 32'h0000_0000;
         bresp_q   <= 2'b00;
         rresp_q   <= 2'b00;
         awready_q <= 1'b0;
         wreq_q    <= 1'b0;
         bvalid_q  <= 1'b0;
         arready_q <= 1'b0;
         rreq_q    <= 1'b0;
         rvalid_q  <= 1'b0;
      end else begin
         w_state_q <= w_state_d;
         r_state_q <= r_state_d;
         w_cnt_q   <= w_cnt_d;
         r_cnt_q   <= r_cnt_d;
         waddr_q   <= waddr_d;
         raddr_q   <= raddr_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
         bresp_q   <= bresp_d;
         rresp_q   <= rresp_d;
         awready_q <= awready_d;
         wreq_q    <= wreq_d;
         bvalid_q  <= bvalid_d;
         arready_q <= arready_d;
         rreq_q    <= rreq_d;
         rvalid_q  <= rvalid_d;
      end
   end

   assign s_axi.up_axi_awready = awready_q;
   assign s_axi.up_axi_wready  = awready_q;
   assign s_axi.up_axi_bvalid  = bvalid_q;
   assign s_axi.up_axi_bresp   = bresp_q;
   assign s_axi.up_axi_arready = arready_q;
   assign s_axi.up_axi_rvalid  = rvalid_q;
   assign s_axi.up_axi_rresp   = rresp_q;
   assign s_axi.up_axi_rdata   = rdata_q;
   assign up_wreq              = wreq_q;
   assign up_waddr             = waddr_q;
   assign up_wdata             = wdata_q;
   assign up_rreq              = rreq_q;
   assign up_raddr             = raddr_q;

endmodule

// File: tb/tb_up_axi_lite_bridge.sv
// ---------------------------------------------------------------------------
// tb_up_axi_lite_bridge
// Directed bench for up_axi_lite_bridge: write/read with acks, timeouts,
// concurrent channels, lone awvalid, stray ack, and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_up_axi_lite_bridge;

   logic        up_clk;
   logic        up_rstn;
   logic        up_wreq;
   logic [11:0] up_waddr;
   logic [31:0] up_wdata;
   logic        up_wack;
   logic        up_rreq;
   logic [11:0] up_raddr;
   logic [31:0] up_rdata;
   logic        up_rack;

   int n_total = 0;
   int n_pass  = 0;

   up_axi_lite_bridge_if #(.AXI_ADDRESS_WIDTH(16)) axi_if ();

   up_axi_lite_bridge #(
      .ADDRESS_WIDTH(12),
      .AXI_ADDRESS_WIDTH(16),
      .TIMEOUT_BITS(5)
   ) dut (
      .up_clk  (up_clk),
      .up_rstn (up_rstn),
      .s_axi   (axi_if),
      .up_wreq (up_wreq),
      .up_waddr(up_waddr),
      .up_wdata(up_wdata),
      .up_wack (up_wack),
      .up_rreq (up_rreq),
      .up_raddr(up_raddr),
      .up_rdata(up_rdata),
      .up_rack (up_rack)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      up_clk = 1'b0;
      forever #5 up_clk = ~up_clk;
   end

   // Absolute time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge up_clk);
      #1;
   endtask

   function automatic logic outs_any();
      return |{axi_if.up_axi_awready, axi_if.up_axi_wready, axi_if.up_axi_bvalid,
               axi_if.up_axi_bresp, axi_if.up_axi_arready, axi_if.up_axi_rvalid,
               axi_if.up_axi_rresp, axi_if.up_axi_rdata, up_wreq, up_waddr,
               up_wdata, up_rreq, up_raddr};
   endfunction

   // Full write; ack_dly = cycles after H+2 before up_wack, negative = never.
   task automatic axi_write(input string tag, input logic [15:0] addr, input logic [31:0] data,
                            input logic [11:0] exp_addr, input int ack_dly);
      int n;
      int exp_n;
      logic [1:0] exp_resp;
      exp_n    = (ack_dly < 0) ? 32 : ack_dly + 1;
      exp_resp = (ack_dly < 0) ? 2'b10 : 2'b00;
      axi_if.up_axi_awaddr  = addr;
      axi_if.up_axi_wdata   = data;
      axi_if.up_axi_wstrb   = 4'h1;
      axi_if.up_axi_awvalid = 1'b1;
      axi_if.up_axi_wvalid  = 1'b1;
      step();
      check({tag, "_awready"}, axi_if.up_axi_awready, 1);
      check({tag, "_wready"}, axi_if.up_axi_wready, 1);
      step();
      axi_if.up_axi_awvalid = 1'b0;
      axi_if.up_axi_wvalid  = 1'b0;
      axi_if.up_axi_awaddr  = 16'hFFFF;
      axi_if.up_axi_wdata   = 32'hFFFF_FFFF;
      check({tag, "_awready_off"}, axi_if.up_axi_awready, 0);
      check({tag, "_wreq"}, up_wreq, 1);
      check({tag, "_waddr"}, up_waddr, exp_addr);
      check({tag, "_wdata"}, up_wdata, data);
      step();
      check({tag, "_wreq_pulse"}, up_wreq, 0);
      n = 0;
      while (!axi_if.up_axi_bvalid && n < 64) begin
         if (n == ack_dly) up_wack = 1'b1;
         step();
         up_wack = 1'b0;
         n++;
      end
      check({tag, "_blat"}, n, exp_n);
      check({tag, "_bresp"}, axi_if.up_axi_bresp, exp_resp);
      check({tag, "_waddr_hold"}, up_waddr, exp_addr);
      check({tag, "_wdata_hold"}, up_wdata, data);
      axi_if.up_axi_bready = 1'b1;
      step();
      axi_if.up_axi_bready = 1'b0;
      check({tag, "_bvalid_off"}, axi_if.up_axi_bvalid, 0);
   endtask

   // Full read; rvalid held for 'hold' cycles before rready.
   task automatic axi_read(input string tag, input logic [15:0] addr, input logic [31:0] data,
                           input logic [11:0] exp_addr, input int ack_dly, input int hold);
      int n;
      int exp_n;
      logic [1:0] exp_resp;
      logic [31:0] exp_data;
      exp_n    = (ack_dly < 0) ? 32 : ack_dly + 1;
      exp_resp = (ack_dly < 0) ? 2'b10 : 2'b00;
      exp_data = (ack_dly < 0) ? 32'h0000_0000 : data;
      axi_if.up_axi_araddr  = addr;
      axi_if.up_axi_arvalid = 1'b1;
      step();
      check({tag, "_arready"}, axi_if.up_axi_arready, 1);
      step();
      axi_if.up_axi_arvalid = 1'b0;
      axi_if.up_axi_araddr  = 16'hFFFF;
      check({tag, "_rreq"}, up_rreq, 1);
      check({tag, "_raddr"}, up_raddr, exp_addr);
      step();
      check({tag, "_rreq_pulse"}, up_rreq, 0);
      n = 0;
      while (!axi_if.up_axi_rvalid && n < 64) begin
         if (n == ack_dly) begin
            up_rack  = 1'b1;
            up_rdata = data;
         end
         step();
         up_rack  = 1'b0;
         up_rdata = 32'hDEAD_BEEF;
         n++;
      end
      check({tag, "_rlat"}, n, exp_n);
      check({tag, "_rresp"}, axi_if.up_axi_rresp, exp_resp);
      check({tag, "_rdata"}, axi_if.up_axi_rdata, exp_data);
      for (int i = 1; i < hold; i++) begin
         step();
         check({tag, "_rvalid_hold"}, axi_if.up_axi_rvalid, 1);
         check({tag, "_rdata_hold"}, axi_if.up_axi_rdata, exp_data);
      end
      axi_if.up_axi_rready = 1'b1;
      step();
      axi_if.up_axi_rready = 1'b0;
      check({tag, "_rvalid_off"}, axi_if.up_axi_rvalid, 0);
      check({tag, "_rdata_clr"}, axi_if.up_axi_rdata, 0);
   endtask

   // Main directed sequence.
   initial begin
      logic seen;
      up_rstn               = 1'b0;
      up_wack               = 1'b0;
      up_rack               = 1'b0;
      up_rdata              = 32'h0000_0000;
      axi_if.up_axi_awvalid = 1'b0;
      axi_if.up_axi_awaddr  = 16'h0000;
      axi_if.up_axi_wvalid  = 1'b0;
      axi_if.up_axi_wdata   = 32'h0000_0000;
      axi_if.up_axi_wstrb   = 4'h0;
      axi_if.up_axi_bready  = 1'b0;
      axi_if.up_axi_arvalid = 1'b0;
      axi_if.up_axi_araddr  = 16'h0000;
      axi_if.up_axi_rready  = 1'b0;
      repeat (2) @(posedge up_clk);
      #1;
      check("reset_outs", outs_any(), 0);
      up_rstn = 1'b1;
      step();

      // Basic write and read.
      axi_write("wr1", 16'h0008, 32'hA5A5_0001, 12'h002, 0);
      axi_read("rd1", 16'h010C, 32'h5359_4944, 12'h043, 0, 4);

      // Timeouts, then normal transactions afterwards.
      axi_write("wr_to", 16'h0040, 32'h0BAD_F00D, 12'h010, -1);
      axi_write("wr2", 16'h0044, 32'h1357_9BDF, 12'h011, 3);
      axi_read("rd_to", 16'h0200, 32'h7777_7777, 12'h080, -1, 1);

      // Read and write started together, acked on different cycles.
      fork
         axi_write("cw", 16'h3FFC, 32'hCAFE_0002, 12'hFFF, 2);
         axi_read("cr", 16'hC123, 32'hBEEF_0003, 12'h048, 0, 2);
      join

      // awvalid alone must not handshake.
      axi_if.up_axi_awvalid = 1'b1;
      axi_if.up_axi_awaddr  = 16'h0010;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         seen = seen | axi_if.up_axi_awready | axi_if.up_axi_wready;
      end
      check("aw_alone_ready", seen, 0);
      axi_write("wr_late_w", 16'h0010, 32'h0000_5A5A, 12'h004, 1);

      // Stray read ack in IDLE is ignored.
      up_rack  = 1'b1;
      up_rdata = 32'h1111_2222;
      step();
      up_rack  = 1'b0;
      step();
      step();
      check("stray_rack_rvalid", axi_if.up_axi_rvalid, 0);
      check("stray_rack_rdata", axi_if.up_axi_rdata, 0);

      // Asynchronous reset while the write waits for its ack.
      axi_if.up_axi_awaddr  = 16'h0020;
      axi_if.up_axi_wdata   = 32'h1234_5678;
      axi_if.up_axi_awvalid = 1'b1;
      axi_if.up_axi_wvalid  = 1'b1;
      step();
      step();
      axi_if.up_axi_awvalid = 1'b0;
      axi_if.up_axi_wvalid  = 1'b0;
      step();
      check("rst_pre_wdata", up_wdata, 32'h1234_5678);
      #2 up_rstn = 1'b0;
      #1;
      check("rst_async_outs", outs_any(), 0);
      check("rst_async_wdata", up_wdata, 0);
      step();
      up_rstn = 1'b1;
      up_wack = 1'b1;
      step();
      up_wack = 1'b0;
      step();
      check("late_wack_bvalid", axi_if.up_axi_bvalid, 0);
      check("late_wack_outs", outs_any(), 0);
      axi_write("wr_post_rst", 16'h0024, 32'h8765_4321, 12'h009, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
